// File: rtl/rbot_moves_pkg.sv
// Shared definitions for the cube-robot move pipeline.
// Holds the move-code alphabet, list geometry and the sequencer state
// encoding. The cube-state updater imports the same package, so both
// sides agree on what each nibble of a move list means.
package rbot_moves_pkg;

  localparam int NUM_MOVES = 50;               // maximum moves per list
  localparam int MOVE_W    = 4;                // bits per move code
  localparam int LIST_W    = NUM_MOVES * MOVE_W;
  localparam int COUNT_W   = 6;                // holds 0..NUM_MOVES

  // Move codes. 0 terminates a list; 1, 14 and 15 are not legal.
  localparam logic [MOVE_W-1:0] MOVE_END = 4'd0;
  localparam logic [MOVE_W-1:0] MV_R     = 4'd2;
  localparam logic [MOVE_W-1:0] MV_RI    = 4'd3;
  localparam logic [MOVE_W-1:0] MV_U     = 4'd4;
  localparam logic [MOVE_W-1:0] MV_UI    = 4'd5;
  localparam logic [MOVE_W-1:0] MV_F     = 4'd6;
  localparam logic [MOVE_W-1:0] MV_FI    = 4'd7;
  localparam logic [MOVE_W-1:0] MV_L     = 4'd8;
  localparam logic [MOVE_W-1:0] MV_LI    = 4'd9;
  localparam logic [MOVE_W-1:0] MV_B     = 4'd10;
  localparam logic [MOVE_W-1:0] MV_BI    = 4'd11;
  localparam logic [MOVE_W-1:0] MV_D     = 4'd12;
  localparam logic [MOVE_W-1:0] MV_DI    = 4'd13;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_FETCH      = 3'd1,
    ST_ISSUE      = 3'd2,
    ST_WAIT_MOTOR = 3'd3,
    ST_DONE       = 3'd4
  } seq_state_t;

  // True for the twelve face-turn codes (R .. Di).
  function automatic logic is_turn_code(input logic [MOVE_W-1:0] code);
    return (code >= MV_R) && (code <= MV_DI);
  endfunction

endpackage

// File: rtl/move_timeout.sv
// Loadable down-counter used as the motor watchdog.
// Ports:
//   clock   - system clock
//   reset   - synchronous active-high reset, clears the count
//   load    - reload the counter with LOAD_VAL
//   tick    - count down by one (saturates at zero)
//   expired - count is zero
// Loading LOAD_VAL = N-1 and ticking once per waiting cycle makes
// 'expired' true during the N-th waiting cycle.
module move_timeout #(
  parameter int            W        = 24,
  parameter logic [W-1:0]  LOAD_VAL = '1
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic tick,
  output logic expired
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= LOAD_VAL;
    end else if (tick && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign expired = (count_reg == '0);

endmodule

// File: rtl/move_sequencer.sv
// Steps a packed move list through the cube one move at a time.
// Each move is issued as a one-cycle move_valid strobe (to the state
// updater and motor together); the next move is fetched only after the
// motor reports motor_done. Invalid codes are skipped and flagged,
// a motor that never finishes raises fault.
// Ports:
//   clock, reset  - system clock, synchronous active-high reset
//   moves         - 200-bit list, move 0 in the top nibble
//   moves_valid   - list strobe, accepted only when idle
//   abort         - cancel the running list
//   motor_ready   - motor can accept a move
//   motor_done    - current physical turn finished (strobe)
//   move_code     - code of the move being issued/executed
//   move_valid    - one-cycle issue strobe
//   busy          - not idle
//   move_count    - list slots consumed so far
//   seq_done      - one-cycle strobe on normal completion
//   bad_move      - sticky: list contained an invalid code
//   fault         - sticky: motor timeout
module move_sequencer
  import rbot_moves_pkg::*;
#(
  parameter int          TO_W           = 24,
  parameter int unsigned TIMEOUT_CYCLES = 10_000_000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [LIST_W-1:0]   moves,
  input  logic                moves_valid,
  input  logic                abort,
  input  logic                motor_ready,
  input  logic                motor_done,
  output logic [MOVE_W-1:0]   move_code,
  output logic                move_valid,
  output logic                busy,
  output logic [COUNT_W-1:0]  move_count,
  output logic                seq_done,
  output logic                bad_move,
  output logic                fault
);

  localparam logic [TO_W-1:0]    TO_LOAD   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [COUNT_W-1:0] COUNT_MAX = COUNT_W'(NUM_MOVES);

  seq_state_t state_reg, state_next;

  logic [LIST_W-1:0]  shreg_reg;
  logic [COUNT_W-1:0] move_count_reg;
  logic [MOVE_W-1:0]  move_code_reg;
  logic               move_valid_reg, move_valid_next;
  logic               seq_done_reg, seq_done_next;
  logic               bad_move_reg, fault_reg;

  logic [MOVE_W-1:0] head;
  logic at_limit, done_accept, to_expired;
  logic accept_list, live, skip_slot, load_code, issue_now, advance, to_tick, time_fault;

  assign head     = shreg_reg[LIST_W-1 -: MOVE_W];
  assign at_limit = (move_count_reg == COUNT_MAX);
  // move_valid is registered, so it is high during the first WAIT_MOTOR
  // cycle; a motor_done in that same cycle belongs to no issued move.
  assign done_accept = motor_done && !move_valid_reg;

  // State register
  always_ff @(posedge clock) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic; abort outranks every other event.
  always_comb begin
    state_next = state_reg;
    if ((state_reg != ST_IDLE) && abort) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE:  if (moves_valid) state_next = ST_FETCH;
        ST_FETCH: begin
          if (at_limit || (head == MOVE_END)) state_next = ST_DONE;
          else if (is_turn_code(head))        state_next = ST_ISSUE;
        end
        ST_ISSUE: if (motor_ready) state_next = ST_WAIT_MOTOR;
        ST_WAIT_MOTOR: begin
          if (done_accept)     state_next = ST_FETCH;
          else if (to_expired) state_next = ST_IDLE;
        end
        ST_DONE:  state_next = ST_IDLE;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  // Output / datapath control decode
  always_comb begin
    accept_list = (state_reg == ST_IDLE) && moves_valid;
    live        = (state_reg != ST_IDLE) && !abort;
    skip_slot   = live && (state_reg == ST_FETCH) && !at_limit &&
                  (head != MOVE_END) && !is_turn_code(head);
    load_code   = live && (state_reg == ST_FETCH) && !at_limit && is_turn_code(head);
    issue_now   = live && (state_reg == ST_ISSUE) && motor_ready;
    advance     = live && (state_reg == ST_WAIT_MOTOR) && done_accept;
    to_tick     = live && (state_reg == ST_WAIT_MOTOR) && !done_accept;
    time_fault  = to_tick && to_expired;
    move_valid_next = issue_now;
    seq_done_next   = live && (state_reg == ST_DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      shreg_reg      <= '0;
      move_count_reg <= '0;
      move_code_reg  <= '0;
      move_valid_reg <= 1'b0;
      seq_done_reg   <= 1'b0;
      bad_move_reg   <= 1'b0;
      fault_reg      <= 1'b0;
    end else begin
      move_valid_reg <= move_valid_next;
      seq_done_reg   <= seq_done_next;
      if (accept_list) begin
        shreg_reg      <= moves;
        move_count_reg <= '0;
        bad_move_reg   <= 1'b0;
        fault_reg      <= 1'b0;
      end
      if (skip_slot || advance) begin
        shreg_reg      <= shreg_reg << MOVE_W;
        move_count_reg <= move_count_reg + 1'b1;
      end
      if (skip_slot)  bad_move_reg  <= 1'b1;
      if (load_code)  move_code_reg <= head;
      if (time_fault) fault_reg     <= 1'b1;
    end
  end

  move_timeout #(
    .W        (TO_W),
    .LOAD_VAL (TO_LOAD)
  ) u_timeout (
    .clock   (clock),
    .reset   (reset),
    .load    (issue_now),
    .tick    (to_tick),
    .expired (to_expired)
  );

  assign move_code  = move_code_reg;
  assign move_valid = move_valid_reg;
  assign busy       = (state_reg != ST_IDLE);
  assign move_count = move_count_reg;
  assign seq_done   = seq_done_reg;
  assign bad_move   = bad_move_reg;
  assign fault      = fault_reg;

endmodule

// File: tb/tb_move_sequencer.sv
// Scoreboard bench for move_sequencer: expected move codes and
// completion records are queued when a list is issued; a monitor on the
// falling edge pops and compares whenever move_valid or seq_done fires.
module tb_move_sequencer;
  import rbot_moves_pkg::*;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic [LIST_W-1:0]  moves = '0;
  logic               moves_valid = 1'b0;
  logic               abort = 1'b0;
  logic               motor_ready = 1'b1;
  logic               motor_done = 1'b0;
  logic [MOVE_W-1:0]  move_code;
  logic               move_valid;
  logic               busy;
  logic [COUNT_W-1:0] move_count;
  logic               seq_done;
  logic               bad_move;
  logic               fault;

  always #5 clock = ~clock;

  move_sequencer #(.TO_W(24), .TIMEOUT_CYCLES(16)) dut (
    .clock       (clock),
    .reset       (reset),
    .moves       (moves),
    .moves_valid (moves_valid),
    .abort       (abort),
    .motor_ready (motor_ready),
    .motor_done  (motor_done),
    .move_code   (move_code),
    .move_valid  (move_valid),
    .busy        (busy),
    .move_count  (move_count),
    .seq_done    (seq_done),
    .bad_move    (bad_move),
    .fault       (fault)
  );

  int vectors = 0;
  int miscompares = 0;
  int mv_seen = 0;
  logic [MOVE_W-1:0] code_q[$];
  logic [6:0]        seq_q[$];   // {bad_move, move_count}
  logic              prev_mv = 1'b0;
  bit                motor_auto = 1'b1;
  logic [LIST_W-1:0] list_v;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clock) begin
    logic [MOVE_W-1:0] exp_code;
    logic [6:0]        exp_seq;
    if (move_valid) begin
      mv_seen++;
      check("mv_width", {31'd0, prev_mv}, 32'd0);
      $display("issue code=%0d count=%0d", move_code, move_count);
      if (code_q.size() == 0) begin
        check("unexpected_move", {28'd0, move_code}, 32'hFFFF);
      end else begin
        exp_code = code_q.pop_front();
        check("move_code", {28'd0, move_code}, {28'd0, exp_code});
      end
    end
    prev_mv = move_valid;
    if (seq_done) begin
      $display("seq_done count=%0d bad=%0d", move_count, bad_move);
      if (seq_q.size() == 0) begin
        check("unexpected_seq_done", 32'd1, 32'd0);
      end else begin
        exp_seq = seq_q.pop_front();
        check("done_count", {26'd0, move_count}, {26'd0, exp_seq[5:0]});
        check("done_bad", {31'd0, bad_move}, {31'd0, exp_seq[6]});
      end
    end
  end

  // Motor model: finishes each turn 5 cycles after the issue strobe.
  initial begin
    forever begin
      @(negedge clock);
      if (move_valid && motor_auto) begin
        repeat (5) @(posedge clock);
        #1 motor_done = 1'b1;
        @(posedge clock);
        #1 motor_done = 1'b0;
      end
    end
  end

  task automatic clear_list();
    list_v = '0;
  endtask

  task automatic set_slot(input int k, input logic [MOVE_W-1:0] c);
    list_v[LIST_W-1-MOVE_W*k -: MOVE_W] = c;
  endtask

  task automatic start_list();
    @(posedge clock);
    #1 moves = list_v;
    moves_valid = 1'b1;
    @(posedge clock);
    #1 moves_valid = 1'b0;
    @(negedge clock);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clock);
      n++;
    end
    check(name, {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_move(input int budget, input string name);
    int n = 0;
    while (!move_valid && n < budget) begin
      @(negedge clock);
      n++;
    end
    check(name, {31'd0, move_valid}, 32'd1);
  endtask

  initial begin
    int base;
    int cnt;

    // Reset state
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_move_valid", {31'd0, move_valid}, 0);
    check("rst_move_code", {28'd0, move_code}, 0);
    check("rst_move_count", {26'd0, move_count}, 0);
    check("rst_seq_done", {31'd0, seq_done}, 0);
    check("rst_bad_move", {31'd0, bad_move}, 0);
    check("rst_fault", {31'd0, fault}, 0);

    // R, U, Fi, end
    clear_list(); set_slot(0, MV_R); set_slot(1, MV_U); set_slot(2, MV_FI);
    code_q.push_back(4'd2); code_q.push_back(4'd4); code_q.push_back(4'd7);
    seq_q.push_back({1'b0, 6'd3});
    start_list();
    wait_idle(200, "t1_idle");
    check("t1_count", {26'd0, move_count}, 3);
    check("t1_bad", {31'd0, bad_move}, 0);
    check("t1_fault", {31'd0, fault}, 0);

    // Full 50-move list of alternating R / Ri; a second list mid-run is ignored
    clear_list();
    for (int k = 0; k < NUM_MOVES; k++) begin
      set_slot(k, (k % 2 == 0) ? MV_R : MV_RI);
      code_q.push_back((k % 2 == 0) ? 4'd2 : 4'd3);
    end
    seq_q.push_back({1'b0, 6'd50});
    start_list();
    repeat (30) @(negedge clock);
    @(posedge clock);
    #1 moves = {NUM_MOVES{MV_DI}};
    moves_valid = 1'b1;
    @(posedge clock);
    #1 moves_valid = 1'b0;
    @(negedge clock);
    wait_idle(1500, "t2_idle");
    check("t2_count", {26'd0, move_count}, 50);

    // R, 15, U, end: invalid slot skipped and flagged
    clear_list(); set_slot(0, MV_R); set_slot(1, 4'd15); set_slot(2, MV_U);
    code_q.push_back(4'd2); code_q.push_back(4'd4);
    seq_q.push_back({1'b1, 6'd3});
    start_list();
    wait_idle(200, "t3_idle");
    check("t3_count", {26'd0, move_count}, 3);
    check("t3_bad", {31'd0, bad_move}, 1);

    // motor_ready low for 20 cycles while in ISSUE
    motor_ready = 1'b0;
    clear_list(); set_slot(0, MV_UI);
    code_q.push_back(4'd5);
    seq_q.push_back({1'b0, 6'd1});
    base = mv_seen;
    start_list();
    repeat (20) @(negedge clock);
    #1;
    check("t4_no_issue", mv_seen, base);
    check("t4_busy", {31'd0, busy}, 1);
    @(posedge clock);
    #1 motor_ready = 1'b1;
    wait_idle(200, "t4_idle");
    check("t4_issued", mv_seen, base + 1);
    check("t4_bad", {31'd0, bad_move}, 0);

    // Motor never finishes: fault after 16 cycles in WAIT_MOTOR
    motor_auto = 1'b0;
    clear_list(); set_slot(0, MV_F);
    code_q.push_back(4'd6);
    start_list();
    wait_move(20, "t5_issue");
    cnt = 0;
    while (busy && cnt < 100) begin
      cnt++;
      @(negedge clock);
    end
    check("t5_wait_cycles", cnt, 16);
    check("t5_fault", {31'd0, fault}, 1);
    check("t5_busy", {31'd0, busy}, 0);
    check("t5_count", {26'd0, move_count}, 0);

    // Abort mid WAIT_MOTOR; new list also clears the fault
    clear_list(); set_slot(0, MV_L); set_slot(1, MV_LI);
    code_q.push_back(4'd8);
    start_list();
    check("t6_fault_clear", {31'd0, fault}, 0);
    wait_move(20, "t6_issue");
    repeat (3) @(negedge clock);
    @(posedge clock);
    #1 abort = 1'b1;
    @(posedge clock);
    #1 abort = 1'b0;
    @(negedge clock);
    check("t6_busy", {31'd0, busy}, 0);
    check("t6_count", {26'd0, move_count}, 0);
    repeat (5) @(negedge clock);
    motor_auto = 1'b1;

    // Reset mid-sequence, then a fresh list runs normally
    clear_list(); set_slot(0, MV_B); set_slot(1, MV_BI); set_slot(2, MV_D);
    code_q.push_back(4'd10);
    start_list();
    wait_move(20, "t7_issue");
    @(negedge clock);
    @(posedge clock);
    #1 reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("t7_busy", {31'd0, busy}, 0);
    check("t7_count", {26'd0, move_count}, 0);
    repeat (10) @(negedge clock);
    clear_list(); set_slot(0, MV_DI);
    code_q.push_back(4'd13);
    seq_q.push_back({1'b0, 6'd1});
    start_list();
    wait_idle(200, "t7_idle");
    check("t7_new_count", {26'd0, move_count}, 1);

    repeat (10) @(negedge clock);
    check("moves_left", code_q.size(), 0);
    check("dones_left", seq_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
